// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the CPU control FSM and the
// byte-addressed data memory. One request at a time; each accepted request
// is checked for size, alignment and range, then either walks the memory
// through SETUP/ACCESS/RESP or reports an error through ERR.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1 (req_ready is high exactly in IDLE). Request fields only need
// to be stable in that cycle. req_valid is ignored while req_ready=0. The
// response is a single-cycle resp_valid pulse with resp_err/resp_rdata
// valid alongside it; there is no backpressure on the response.

`ifndef MEM
`define MEM 3'b100
`endif

module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  // response side
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  // memory side
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  output logic [1:0]       mem_size,
  output logic             mem_sign_ext,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_status,
  input  logic [31:0]      mem_rdata,
  // debug
  output logic [CNT_W-1:0] ld_count,
  output logic [CNT_W-1:0] st_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        we_q;
  logic        accept;
  logic        req_err;
  logic [32:0] last_byte;
  logic [32:0] bytes_m1;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready & req_valid;
  assign dbg_state = state;

  // Request legality: illegal size, misalignment, or last byte past memory end.
  // Done in 33 bits so addresses near 2^32 cannot wrap back into range.
  always_comb begin
    bytes_m1 = 33'd0;
    req_err  = 1'b0;
    case (req_size)
      2'b00: bytes_m1 = 33'd0;
      2'b01: begin
        bytes_m1 = 33'd1;
        if (req_addr[0]) req_err = 1'b1;
      end
      2'b10: begin
        bytes_m1 = 33'd3;
        if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      end
      default: req_err = 1'b1;
    endcase
    last_byte = {1'b0, req_addr} + bytes_m1;
    if (last_byte >= 33'(MEM_BYTES)) req_err = 1'b1;
  end

  // Next-state logic for the access sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_err ? ERR : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch request fields at accept; they then hold until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      mem_size     <= 2'b00;
      mem_sign_ext <= 1'b0;
      we_q         <= 1'b0;
    end else if (accept) begin
      mem_addr     <= req_addr;
      mem_wdata    <= req_wdata;
      mem_size     <= req_size;
      mem_sign_ext <= req_signed;
      we_q         <= req_we;
    end
  end

  // Memory controls and response flags are registered from the next state
  // so they switch cleanly on the clock edge. we_q is already valid when
  // the next state is ACCESS because it was latched at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_status <= 3'b000;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      mem_wr_en  <= (state_nxt == ACCESS) &  we_q;
      mem_rd_en  <= (state_nxt == ACCESS) & ~we_q;
      mem_status <= ((state_nxt == SETUP) || (state_nxt == ACCESS)) ? `MEM : 3'b000;
      resp_valid <= (state_nxt == RESP) || (state_nxt == ERR);
      resp_err   <= (state_nxt == ERR);
    end
  end

  // Read data capture at the end of ACCESS; stores and errors return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= 32'd0;
    end else if (state == ACCESS) begin
      resp_rdata <= we_q ? 32'd0 : mem_rdata;
    end else if (state_nxt == ERR) begin
      resp_rdata <= 32'd0;
    end
  end

  // Completed-access counters, bumped as RESP closes; they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_count <= '0;
      st_count <= '0;
    end else if (state == RESP) begin
      if (we_q) st_count <= st_count + 1'b1;
      else      ld_count <= ld_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases followed by random traffic, checked
// cycle by cycle against a byte-array reference of the memory contents and
// transaction-level latency/counter expectations.

`ifndef MEM
`define MEM 3'b100
`endif

module tb_lsu_mem_ctrl;

  localparam int MEM_BYTES = 1024;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wr_en, mem_rd_en, mem_sign_ext;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_status;
  logic [15:0] ld_count, st_count;
  logic [2:0]  dbg_state;

  // second instance with narrow counters, fed the same traffic
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic        b_mem_wr_en, b_mem_rd_en, b_mem_sign_ext;
  logic [1:0]  b_mem_size;
  logic [2:0]  b_mem_status, b_dbg_state;
  logic [1:0]  b_ld_count, b_st_count;

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_size(mem_size),
    .mem_sign_ext(mem_sign_ext), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_status(mem_status), .mem_rdata(mem_rdata),
    .ld_count(ld_count), .st_count(st_count), .dbg_state(dbg_state)
  );

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_err(b_resp_err), .resp_rdata(b_resp_rdata),
    .mem_wr_en(b_mem_wr_en), .mem_rd_en(b_mem_rd_en), .mem_size(b_mem_size),
    .mem_sign_ext(b_mem_sign_ext), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_status(b_mem_status), .mem_rdata(mem_rdata),
    .ld_count(b_ld_count), .st_count(b_st_count), .dbg_state(b_dbg_state)
  );

  // environment memory: asynchronous extended read, write on clock edge
  logic [7:0] env_mem [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  always_comb begin
    logic [9:0] a;
    a = mem_addr[9:0];
    mem_rdata = 32'd0;
    case (mem_size)
      2'b00: mem_rdata = mem_sign_ext ? {{24{env_mem[a][7]}}, env_mem[a]} : {24'd0, env_mem[a]};
      2'b01: mem_rdata = mem_sign_ext ? {{16{env_mem[a+10'd1][7]}}, env_mem[a+10'd1], env_mem[a]}
                                      : {16'd0, env_mem[a+10'd1], env_mem[a]};
      default: mem_rdata = {env_mem[a+10'd3], env_mem[a+10'd2], env_mem[a+10'd1], env_mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      env_mem[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_size != 2'b00) env_mem[mem_addr[9:0]+10'd1] <= mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        env_mem[mem_addr[9:0]+10'd2] <= mem_wdata[23:16];
        env_mem[mem_addr[9:0]+10'd3] <= mem_wdata[31:24];
      end
    end
  end

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int ld_cnt = 0;
  int st_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] addr);
    longint last;
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && addr[0]) return 1'b1;
    if (sz == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
    last = longint'(addr) + longint'(size_bytes(sz)) - 1;
    return last >= longint'(MEM_BYTES);
  endfunction

  // value the memory should return, from the reference bytes
  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn, input logic [31:0] addr);
    int a;
    int n;
    longint v;
    a = int'(addr);
    n = size_bytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[a+i]) << (8*i));
    if (sgn && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < size_bytes(sz); i++) ref_mem[int'(addr)+i] = data[8*i +: 8];
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ld"}, 32'(ld_count), 32'(ld_cnt % 65536));
    check({tag, "_st"}, 32'(st_count), 32'(st_cnt % 65536));
    check({tag, "_ld_w2"}, 32'(b_ld_count), 32'(ld_cnt % 4));
    check({tag, "_st_w2"}, 32'(b_st_count), 32'(st_cnt % 4));
  endtask

  // driver: called at a negedge with the DUT idle; returns at a negedge
  // with the DUT idle again (so requests can run back to back)
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit do_rst);
    bit e;
    e = model_err(sz, addr);
    check("ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    exp_q.push_back(e ? 32'd0 : (we ? 32'd0 : model_load(sz, sgn, addr)));
    @(posedge clk); #1;
    // scramble fields and poke req_valid while busy: must not matter
    req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom);
    req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);                                   // cycle 1
    if (e) begin
      req_valid = 1'b0;
      check("err_valid", 32'(resp_valid), 32'd1);
      check("err_flag", 32'(resp_err), 32'd1);
      check("err_rdata", resp_rdata, exp_q.pop_front());
      check("err_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
      check("err_status", 32'(mem_status), 32'd0);
      @(negedge clk);                                 // cycle 2
      check("err_ready_back", 32'(req_ready), 32'd1);
      check("err_no_2nd_resp", 32'(resp_valid), 32'd0);
      check_counts("err_cnt");
      return;
    end
    check("setup_status", 32'(mem_status), 32'(`MEM));
    check("setup_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
    check("setup_busy", 32'({req_ready, resp_valid}), 32'd0);
    @(negedge clk);                                   // cycle 2
    check("acc_wr_en", 32'(mem_wr_en), 32'(we));
    check("acc_rd_en", 32'(mem_rd_en), 32'(!we));
    check("acc_status", 32'(mem_status), 32'(`MEM));
    check("acc_addr", mem_addr, addr);
    check("acc_size", 32'(mem_size), 32'(sz));
    check("acc_sign", 32'(mem_sign_ext), 32'(sgn));
    if (we) check("acc_wdata", mem_wdata, wdata);
    check("acc_no_resp", 32'(resp_valid), 32'd0);
    if (do_rst) begin
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);                                 // cycle 3, after reset edge
      rst = 1'b0;
      void'(exp_q.pop_front());
      ld_cnt = 0; st_cnt = 0;
      check("rst_mid_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
      check("rst_mid_resp", 32'(resp_valid), 32'd0);
      check("rst_mid_status", 32'(mem_status), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check_counts("rst_mid_cnt");
      return;
    end
    @(negedge clk);                                   // cycle 3
    req_valid = 1'b0;
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_err", 32'(resp_err), 32'd0);
    check("resp_rdata", resp_rdata, exp_q.pop_front());
    check("resp_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
    check("resp_status", 32'(mem_status), 32'd0);
    if (we) begin model_store(sz, addr, wdata); st_cnt++; end
    else ld_cnt++;
    @(negedge clk);                                   // cycle 4
    check("ready_back", 32'(req_ready), 32'd1);
    check("no_2nd_resp", 32'(resp_valid), 32'd0);
    check_counts("cnt");
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < MEM_BYTES; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      env_mem[i] = b;
      ref_mem[i] = b;
    end
    // reset: two cycles high
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
    check("rst_status", 32'(mem_status), 32'd0);
    check("rst_resp", 32'({resp_valid, resp_err}), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check_counts("rst_cnt");
    rst = 1'b0;

    // directed cases
    run_req(1'b1, 2'b10, 1'b0, 32'h40,  32'h12345678, 1'b0);
    run_req(1'b0, 2'b10, 1'b0, 32'h40,  32'h0, 1'b0);
    run_req(1'b0, 2'b00, 1'b1, 32'h41,  32'h0, 1'b0);
    run_req(1'b1, 2'b00, 1'b0, 32'h41,  32'h000000F0, 1'b0);
    run_req(1'b0, 2'b00, 1'b1, 32'h41,  32'h0, 1'b0);
    run_req(1'b0, 2'b01, 1'b1, 32'h40,  32'h0, 1'b0);
    run_req(1'b0, 2'b10, 1'b0, 32'h42,  32'h0, 1'b0);
    run_req(1'b1, 2'b01, 1'b0, 32'h43,  32'hDEADBEEF, 1'b0);
    run_req(1'b0, 2'b11, 1'b0, 32'h40,  32'h0, 1'b0);
    run_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, 1'b0);
    run_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0);
    run_req(1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, 1'b0);
    run_req(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 1'b0);
    run_req(1'b1, 2'b01, 1'b0, 32'h3FE, 32'h0000ABCD, 1'b0);
    run_req(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0);
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);   // reset mid-access
    for (int i = 0; i < 5; i++)                         // wrap in the 2-bit copy
      run_req(1'b0, 2'b10, 1'b0, 32'(4*i), 32'h0, 1'b0);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0: addr = 32'($urandom_range(0, MEM_BYTES-1));
        1: addr = 32'($urandom_range(MEM_BYTES-8, MEM_BYTES+8));
        2: addr = $urandom;
        default: addr = 32'($urandom_range(0, 255)) << 2;
      endcase
      run_req(1'($urandom), sz, 1'($urandom), addr, $urandom, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store initiator between the multi-cycle CPU control FSM and the byte-addressed data memory. Accepts one load or store request at a time, checks alignment and range, then drives the memory's write-enable, read-enable, size, sign-extend, address, write-data and status lines through a fixed setup/access sequence. Captures the memory's asynchronous read data into a register and returns it with a one-cycle response pulse. Keeps wrapping load/store counters for debug.

## Interface
- MEM_BYTES, 1024: memory size in bytes. Any address at or above this value is an error.
- CNT_W, 16: width of the load and store counters.

Ports:
- clk in 1: single clock. All state updates on posedge.
- rst in 1: synchronous, active-high reset.
- req_valid in 1: request present.
- req_ready out 1: block can accept a request. Equals state==IDLE.
- req_we in 1: 1 = store, 0 = load.
- req_size in 2: access size. 00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed in 1: load sign-extension request, forwarded to memory.
- req_addr in 32: byte address.
- req_wdata in 32: store data, right-justified.
- resp_valid out 1: one-cycle completion pulse.
- resp_err out 1: valid with resp_valid. Misaligned, illegal size, or out of range.
- resp_rdata out 32: load result. 0 for stores and errors.
- mem_wr_en out 1 / mem_rd_en out 1: memory enables.
- mem_size out 2 / mem_sign_ext out 1: size and extension, as in the request encoding.
- mem_addr out 32 / mem_wdata out 32: latched address and store data.
- mem_status out 3: `MEM (from define.v) while accessing, otherwise 3'b000. `MEM is nonzero.
- mem_rdata in 32: memory read data, already extended by the memory.
- ld_count out CNT_W / st_count out CNT_W: completed, error-free loads and stores. Both wrap.

## Operation
- State machine: IDLE, SETUP, ACCESS, RESP, ERR.
- **IDLE**
  - A request is accepted when req_valid=1. The request fields are latched into mem_addr, mem_wdata, mem_size, mem_sign_ext and a we register.
  - An error is flagged at accept when any of these holds:
    - size==11
    - halfword with addr[0]=1
    - word with addr[1:0]!=0
    - addr + bytes − 1 ≥ MEM_BYTES
  - Next state is ERR if flagged, otherwise SETUP.
- **SETUP**
  - mem_status=`MEM.
  - Both enables are 0. This gives address and size one full cycle of settling.
  - Next state is ACCESS.
- **ACCESS**
  - mem_status=`MEM.
  - Exactly one enable is 1: mem_wr_en for a store, mem_rd_en for a load.
  - On the closing edge:
    - a load captures mem_rdata into resp_rdata;
    - a store loads 0 into resp_rdata.
  - Next state is RESP.
- **RESP**
  - resp_valid=1, resp_err=0, mem_status=0, enables 0.
  - The matching counter increments at this edge.
  - Next state is IDLE.
- **ERR**
  - resp_valid=1, resp_err=1, resp_rdata=0.
  - No enable is ever asserted and mem_status stays 0.
  - Counters are unchanged.
  - Next state is IDLE.
- Enables and mem_status are registered outputs decoded from the next state, so they are glitch-free.
- Outside SETUP and ACCESS, mem_addr, mem_wdata, mem_size and mem_sign_ext hold their last values.
- The requester must hold its fields stable only in the accept cycle.

## Timing
- Reset (rst=1 at a posedge):
  - state becomes IDLE;
  - all outputs become 0 except req_ready, which becomes 1;
  - both counters become 0.
- Reset mid-operation: any state returns to IDLE on that edge. Enables drop at the same edge and no response is issued.
- Good access, with accept at edge 0:
  - SETUP during cycle 1;
  - enable high during cycle 2;
  - resp_valid during cycle 3;
  - req_ready back to 1 in cycle 4.
  - Latency is 3 cycles from accept to response for both loads and stores.
- Error: resp_valid and resp_err are high in cycle 1. Latency is 1 cycle.
- req_valid is ignored while req_ready=0. No queuing.
- resp_valid is never high on two consecutive cycles.
- A new request may be presented in the cycle after RESP or ERR.
- Counters wrap from 2^CNT_W−1 to 0.

## Test plan
- **Reset:**
  - Stimulus: rst=1 for 2 cycles, then 0.
  - Response: req_ready=1; enables, mem_status, resp_* and counters all 0.
- **Word store then load:**
  - Stimulus: store 0x12345678 to 0x40, then load word from 0x40.
  - Response: mem_wr_en high exactly one cycle with mem_addr=0x40 and mem_status=`MEM. The load's resp_rdata equals mem_rdata sampled in ACCESS. resp_valid 3 cycles after each accept. st_count=1, ld_count=1.
- **Signed byte load:**
  - Stimulus: load from 0x41 with req_signed=1 and size=00.
  - Response: mem_sign_ext=1, mem_size=00, mem_rd_en one cycle. The result is forwarded unchanged.
- **Misalignment and illegal size:**
  - Stimulus: word at 0x42, halfword at 0x43, and size=11.
  - Response: each gives resp_err=1 one cycle after accept. No enable and no `MEM status. Counters unchanged.
- **Range check:**
  - Stimulus: word at 0x3FC, then word at 0x3FE and byte at 0x400.
  - Response: 0x3FC succeeds. 0x3FE errors as misaligned. 0x400 errors as out of range.
- **Reset mid-access and wrap:**
  - Stimulus: assert rst while in ACCESS. Separately, with CNT_W=2, perform 4 loads.
  - Response: the reset case shows enables 0 next cycle and no resp_valid. The wrap case shows ld_count=0.
